// File: rtl/exe_divider.sv
// Iterative restoring divider for DIV/DIVU in the EXE stage.
// One quotient bit per cycle on operand magnitudes, sign fix-up applied in a final cycle.
module exe_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_a_raw;
    logic [CNT_W-1:0] r_count;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_b_zero;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_quot_fix;
    logic [WIDTH-1:0] w_rem_fix;

    // Magnitude of 0x80..0 stays 0x80..0, read as unsigned 2^(WIDTH-1).
    assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // The extra top bit of the trial difference acts as the borrow.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_trial[WIDTH+1];

    assign w_quot_fix = r_q_neg ? -r_dvd : r_dvd;
    assign w_rem_fix  = r_r_neg ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_a_raw  <= '0;
            r_count  <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd    <= w_a_mag;
                        r_dvs    <= w_b_mag;
                        r_a_raw  <= a;
                        r_b_zero <= (b == '0);
                        r_q_neg  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_r_neg  <= is_signed & a[WIDTH-1];
                        r_rem    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem   <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_ge};
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        // Release the pipeline as the result cycle begins.
                        r_busy  <= 1'b0;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_quot  <= r_b_zero ? '1 : w_quot_fix;
                    r_remo  <= r_b_zero ? r_a_raw : w_rem_fix;
                    r_dbz   <= r_b_zero;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_exe_divider.sv
// Directed self-checking bench for exe_divider: timing, signed/unsigned results,
// divide-by-zero, overflow, start-while-busy and reset mid-operation.
module tb_exe_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    exe_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_signed  (is_signed),
        .a          (a_in),
        .b          (b_in),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start, follow the operation cycle by cycle, then check the results.
    // c counts sample points #1 after each edge; c=0 follows the accepting edge.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, input bit interfere);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        logic [31:0] hold_q;
        logic [31:0] hold_r;
        is_signed = sgn;
        a_in      = av;
        b_in      = bv;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (c == 32) chk({tag, " busy_low_in_finish"}, {31'b0, busy}, 32'd0);
            if (interfere && c == 10) begin
                start     = 1'b1;
                is_signed = ~sgn;
                a_in      = 32'hDEAD_BEEF;
                b_in      = 32'h0000_0003;
            end
            if (interfere && c == 11) start = 1'b0;
        end
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd32);
        chk({tag, " done_cycle"}, 32'(done_at), 32'd33);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, ez});
        $display("op %s: a=%h b=%h signed=%0b -> q=%h r=%h dbz=%0b",
                 tag, av, bv, sgn, quotient, remainder, div_by_zero);
        hold_q = quotient;
        hold_r = remainder;
        done_cnt = 0;
        for (int c = 0; c < (interfere ? 40 : 2); c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk({tag, " no_extra_done"}, 32'(done_cnt), 32'd0);
        chk({tag, " quotient_hold"}, quotient, hold_q);
        chk({tag, " remainder_hold"}, remainder, hold_r);
    endtask

    initial begin
        int done_cnt;
        // Reset with a start pending: reset must win.
        start = 1'b1;
        a_in  = 32'd5;
        b_in  = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset dbz", {31'b0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        chk("idle after reset busy", {31'b0, busy}, 32'd0);

        run_op("divu_100_7", 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 1'b0, 1'b0);
        run_op("div_m7_2",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("div_7_m2",   1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 1'b0);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("divu_by0",   1'b0, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
        run_op("div_by0",    1'b1, 32'hF000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 32'hF000_0001, 1'b1, 1'b0);
        run_op("div_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        run_op("divu_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("divu_max",   1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 1'b0);
        run_op("busy_start", 1'b0, 32'h0000_03E8, 32'h0000_0009, 32'h0000_006F, 32'h0000_0001, 1'b0, 1'b1);

        // Reset in the middle of an operation.
        is_signed = 1'b0;
        a_in      = 32'h0000_0050;
        b_in      = 32'h0000_0003;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst quotient", quotient, 32'd0);
        chk("midrst remainder", remainder, 32'd0);
        chk("midrst dbz", {31'b0, div_by_zero}, 32'd0);
        $display("op midrst: reset applied during operation");
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("midrst no_done", 32'(done_cnt), 32'd0);
        run_op("after_rst",  1'b0, 32'h0000_0050, 32'h0000_0003, 32'h0000_001A, 32'h0000_0002, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
